// File: rtl/mul_ace_pkg.sv
// rtl/mul_ace_pkg.sv - shared types and default widths for the mul_ace scheduler
// Purpose: FSM state encoding and default parameter values used by the
//          scheduler and its round-robin arbiter.
// Ports:   none (package).
package mul_ace_pkg;

    localparam int MUL_W    = 8;
    localparam int MUL_NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_ace_rr_arb.sv
// rtl/mul_ace_rr_arb.sv - round-robin arbiter with advance strobe
// Purpose: grants the first requester with req set, searching cyclically
//          from an internal pointer; the pointer moves past the granted
//          index only when adv is strobed.
// Ports:   clk, rst       - clock, async active-high reset
//          req[N_REQ]     - request vector
//          adv            - commit the current grant (pointer advances)
//          gnt[N_REQ]     - one-hot grant (combinational)
//          gnt_idx[IDW]   - encoded grant index
//          gnt_any        - some request is granted
module mul_ace_rr_arb
    import mul_ace_pkg::*;
#(
    parameter int N_REQ = MUL_NREQ,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        sel     = '0;
        // Walk the requesters starting at the pointer; first hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            sel = IDW'(idx);
            if (!gnt_any && req[sel]) begin
                gnt_any  = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && gnt_any) begin
            ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_ace_sched.sv
// rtl/mul_ace_sched.sv - round-robin scheduler around a shared shift-add multiplier
// Purpose: accepts one operand pair at a time from N_REQ requesters, runs a
//          W-cycle unsigned shift-add multiply, and returns the product
//          tagged with the owning requester index.
// Ports:   clk, rst                 - clock, async active-high reset
//          req_valid/req_a/req_b    - per-requester operand offers (W-bit packed)
//          req_ready                - one-hot accept strobe
//          res_valid/res_data/res_id- product and owner, held until res_ready
//          res_ready                - downstream accept
//          busy                     - a multiply or unconsumed result is pending
module mul_ace_sched
    import mul_ace_pkg::*;
#(
    parameter int N_REQ = MUL_NREQ,
    parameter int W     = MUL_W,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [2*W-1:0]     res_data,
    output logic [IDW-1:0]     res_id,
    input  logic               res_ready,
    output logic               busy
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             adv;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;

    mul_ace_rr_arb #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .adv     (adv),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    assign adv = (state_q == IDLE) && gnt_any;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_d      = a_sel;
                    b_d      = b_sel;
                    acc_d    = '0;
                    cnt_d    = '0;
                    res_id_d = gnt_idx;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // One partial product per cycle; no early exit on zero operands.
                if (b_q[0]) begin
                    acc_d = acc_q + ({{W{1'b0}}, a_q} << cnt_q);
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    res_data_d = acc_d;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    // Grant is combinational from req_valid, so force it low while reset is
    // applied to keep every output at zero during reset.
    assign req_ready = ((state_q == IDLE) && !rst) ? gnt : '0;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_mul_ace_sched.sv
// tb/tb_mul_ace_sched.sv - self-checking bench for mul_ace_sched
module tb_mul_ace_sched;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int IDW = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic [2*W-1:0]   res_data;
    logic [IDW-1:0]   res_id;
    logic             res_ready = 1'b1;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mul_ace_sched #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: request/response behaviour in plain terms.
    // phase 0 = waiting for work, 1 = computing, 2 = result offered.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    int          m_id    = 0;
    logic [31:0] m_prod  = 0;
    logic [31:0] m_last  = 0;

    always @(negedge clk) begin
        int           gi;
        logic [N-1:0] exp_g;
        if (rst) begin
            chk("reset_outputs", {req_ready, res_valid, busy, res_id, res_data}, 0);
            m_phase = 0;
            m_ptr   = 0;
            m_last  = 0;
        end else begin
            case (m_phase)
                0: begin
                    exp_g = '0;
                    gi    = -1;
                    for (int k = 0; k < N; k++) begin
                        if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
                    end
                    if (gi >= 0) exp_g[gi] = 1'b1;
                    chk("idle_req_ready", req_ready, exp_g);
                    chk("idle_busy_valid", {busy, res_valid}, 0);
                    chk("idle_res_data_hold", res_data, m_last);
                    if (gi >= 0) begin
                        m_id    = gi;
                        m_prod  = req_a[gi*W +: W] * req_b[gi*W +: W];
                        m_ptr   = (gi + 1) % N;
                        m_cnt   = W;
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("busy_flags", {req_ready, res_valid, busy}, 1);
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        m_last  = m_prod;
                    end
                end
                default: begin
                    chk("done_flags", {req_ready, res_valid, busy}, 3);
                    chk("done_res_data", res_data, m_prod);
                    chk("done_res_id", res_id, m_id);
                    if (res_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Transaction log gathered while stepping the bench.
    int           g_ids[$];
    int           g_cyc[$];
    int           r_data[$];
    int           r_ids[$];
    int           r_cyc[$];
    logic [N-1:0] keep = '0;

    task automatic clear_log();
        g_ids.delete(); g_cyc.delete(); r_data.delete(); r_ids.delete(); r_cyc.delete();
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            logic [N-1:0] g;
            @(negedge clk);
            g = req_ready;
            if (g != 0) begin
                g_ids.push_back(g[1] ? 1 : 0);
                g_cyc.push_back(cyc);
            end
            if (res_valid && res_ready) begin
                r_data.push_back(int'(res_data));
                r_ids.push_back(int'(res_id));
                r_cyc.push_back(cyc);
            end
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (g[i] && !keep[i]) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int id, input int a, input int b);
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
        req_valid[id]    = 1'b1;
    endtask

    task automatic single(input int id, input int a, input int b, input int exp);
        clear_log();
        set_req(id, a, b);
        run_cycles(12);
        chk("single_grant_count", g_ids.size(), 1);
        chk("single_result_count", r_data.size(), 1);
        if (g_ids.size() == 1 && r_data.size() == 1) begin
            chk("single_grant_id", g_ids[0], id);
            chk("single_latency", r_cyc[0] - g_cyc[0], 9);
            chk("single_product", r_data[0], exp);
            chk("single_res_id", r_ids[0], id);
        end
    endtask

    typedef struct { int id; int a; int b; int p; } vec_t;
    vec_t vecs[4] = '{'{0, 13, 11, 143}, '{1, 255, 255, 65025}, '{0, 0, 200, 0}, '{1, 1, 255, 255}};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_state", {req_ready, res_valid, busy, res_id, res_data}, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Single requests and boundary operands
        foreach (vecs[i]) single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);

        // Contention: both requesters valid out of reset
        rst = 1'b1;
        set_req(0, 3, 5);
        set_req(1, 7, 9);
        @(posedge clk); #2;
        rst = 1'b0;
        clear_log();
        run_cycles(25);
        chk("cont_grant_count", g_ids.size(), 2);
        chk("cont_result_count", r_data.size(), 2);
        if (g_ids.size() == 2 && r_data.size() == 2) begin
            chk("cont_first_id", r_ids[0], 0);
            chk("cont_first_data", r_data[0], 15);
            chk("cont_second_id", r_ids[1], 1);
            chk("cont_second_data", r_data[1], 63);
            chk("cont_second_accept_cycle", g_cyc[1], r_cyc[0] + 1);
        end

        // Fairness: requester 0 always valid, requester 1 once
        clear_log();
        keep = 2'b01;
        set_req(0, 4, 6);
        run_cycles(3);
        set_req(1, 10, 12);
        run_cycles(35);
        chk("fair_grant_count_min", g_ids.size() >= 3, 1);
        if (g_ids.size() >= 3) begin
            chk("fair_grant0", g_ids[0], 0);
            chk("fair_grant1", g_ids[1], 1);
            chk("fair_grant2", g_ids[2], 0);
        end
        if (r_data.size() >= 2) begin
            chk("fair_res0", r_data[0], 24);
            chk("fair_res1", r_data[1], 120);
        end else begin
            chk("fair_result_count", r_data.size(), 2);
        end
        keep = '0;
        req_valid = '0;
        run_cycles(12);

        // Backpressure: result held for 20 cycles, waiting request not granted
        clear_log();
        res_ready = 1'b0;
        set_req(0, 9, 7);
        run_cycles(11);
        chk("bp_valid_up", res_valid, 1);
        set_req(1, 5, 5);
        run_cycles(20);
        chk("bp_single_grant", g_ids.size(), 1);
        chk("bp_data_held", res_data, 63);
        chk("bp_id_held", res_id, 0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", res_valid, 1);
        @(negedge clk);
        chk("bp_idle_after", busy, 0);
        chk("bp_next_grant", req_ready, 2'b10);
        @(posedge clk); #2;
        req_valid[1] = 1'b0;
        run_cycles(12);

        // Reset in the middle of a multiply
        set_req(0, 200, 100);
        @(negedge clk);
        chk("rst_mid_grant", req_ready, 2'b01);
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {req_ready, res_valid, busy, res_id, res_data}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_log();
        run_cycles(12);
        chk("rst_no_result", r_data.size(), 0);
        single(0, 2, 3, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
